// File: rtl/rll_key_pkg.sv
// Shared types and constants for the RLL key loader.
// Holds the FSM state enum, frame length and parameter defaults.
package rll_key_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_LOCK
    } state_e;

    localparam int DEF_KEY_W   = 16;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_MAX_TRY = 3;

    // Key bits plus one even-parity bit.
    function automatic int frame_len(input int key_w);
        return key_w + 1;
    endfunction

    localparam int FRAME_LEN = frame_len(DEF_KEY_W);

endpackage

// File: rtl/rll_key_loader_shifter.sv
// Serial frame capture: shift register, bit counter and running parity.
// Ports: clk, rst, clr (sync clear), shift_en, bit_in -> key, cnt, parity, done.
module rll_key_shifter
    import rll_key_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int CNT_W = $clog2(DEF_KEY_W + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] key,
    output logic [CNT_W-1:0] cnt,
    output logic             parity,
    output logic             done
);

    localparam int FLEN = frame_len(KEY_W);

    logic [KEY_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        par_d = par_q;
        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
            par_d = 1'b0;
        end else if (shift_en && (cnt_q < CNT_W'(FLEN))) begin
            // Counter saturates at the frame length; it never wraps.
            cnt_d = cnt_q + CNT_W'(1);
            par_d = par_q ^ bit_in;
            // The parity bit only feeds the running parity, so the
            // first key bit ends up at the MSB.
            if (cnt_q < CNT_W'(KEY_W)) begin
                sh_d = {sh_q[KEY_W-2:0], bit_in};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    assign key    = sh_q;
    assign cnt    = cnt_q;
    assign parity = par_q;
    assign done   = (cnt_q == CNT_W'(FLEN));

endmodule

// File: rtl/rll_key_loader.sv
// Loads a parity-protected key from serial storage onto a locked netlist key bus.
// Ports: start, nvm_req/nvm_valid/nvm_bit, key_out, key_valid, busy, err, try_cnt.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MAX_TRY = DEF_MAX_TRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             nvm_req,
    input  logic             nvm_valid,
    input  logic             nvm_bit,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic [1:0]       try_cnt
);

    localparam int CNT_W = $clog2(KEY_W + 2);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             nvm_req_q, nvm_req_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [1:0]       try_q, try_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             xfer;
    logic             restart;
    logic             bad;
    logic             last_xfer;
    logic [1:0]       try_inc;
    logic [KEY_W-1:0] sh_key;
    logic [CNT_W-1:0] bit_cnt;
    logic             sh_par;
    logic             sh_done;

    // nvm_req is only high in LOAD, so this also masks stray valids.
    assign xfer      = nvm_req_q & nvm_valid;
    assign last_xfer = xfer && (bit_cnt == CNT_W'(KEY_W));
    assign try_inc   = try_q + 2'd1;

    rll_key_shifter #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (restart),
        .shift_en (xfer),
        .bit_in   (nvm_bit),
        .key      (sh_key),
        .cnt      (bit_cnt),
        .parity   (sh_par),
        .done     (sh_done)
    );

    always_comb begin
        state_d     = state_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        try_d       = try_q;
        tmo_d       = tmo_q;
        restart     = 1'b0;
        bad         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    restart = 1'b1;
                    try_d   = 2'd0;
                end
            end
            S_LOAD: begin
                if (sh_done) begin
                    state_d = S_CHECK;
                end else if (xfer) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT.
                    bad = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CHECK: begin
                if (!sh_par) begin
                    state_d     = S_DONE;
                    key_out_d   = sh_key;
                    key_valid_d = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    restart     = 1'b1;
                    key_out_d   = '0;
                    key_valid_d = 1'b0;
                    try_d       = 2'd0;
                end
            end
            S_LOCK: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bad) begin
            try_d = try_inc;
            if (int'(try_inc) < MAX_TRY) begin
                state_d = S_LOAD;
                restart = 1'b1;
            end else begin
                state_d = S_LOCK;
            end
        end

        if (restart) begin
            tmo_d = '0;
        end

        // Drop the request once the parity bit has been taken.
        nvm_req_d = (state_d == S_LOAD) && !last_xfer;
        busy_d    = (state_d == S_LOAD) || (state_d == S_CHECK);
        err_d     = err_q || (state_d == S_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            nvm_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            try_q       <= 2'd0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            nvm_req_q   <= nvm_req_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            try_q       <= try_d;
            tmo_q       <= tmo_d;
        end
    end

    assign nvm_req   = nvm_req_q;
    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign try_cnt   = try_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader.
// Scoreboard queue of expected keys; one task per scenario.
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        nvm_valid = 1'b0;
    logic        nvm_bit = 1'b0;
    logic        nvm_req;
    logic [15:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        err;
    logic [1:0]  try_cnt;

    int checks = 0;
    int errors = 0;
    int zero_viol = 0;
    logic [15:0] exp_q[$];

    rll_key_loader #(
        .KEY_W   (16),
        .TIMEOUT (255),
        .MAX_TRY (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nvm_req   (nvm_req),
        .nvm_valid (nvm_valid),
        .nvm_bit   (nvm_bit),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .try_cnt   (try_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] good_frame(input logic [15:0] k);
        return {k, ^k};
    endfunction

    function automatic logic [16:0] bad_frame(input logic [15:0] k);
        return {k, ~^k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends bits first..last of a frame; gap inserts an idle cycle between bits.
    task automatic send_bits(input logic [16:0] fr, input int first,
                             input int last, input int gap);
        int n;
        for (int i = first; i <= last; i++) begin
            n = 0;
            while (!nvm_req && n < 20) begin
                tick();
                n++;
            end
            if (!nvm_req) begin
                errors++;
                $display("FAIL nvm_req_wait: got %0b want 1 (bit %0d)", nvm_req, i);
            end
            nvm_valid = 1'b1;
            nvm_bit   = fr[16-i];
            tick();
            if (key_out !== 16'h0 || key_valid !== 1'b0) zero_viol++;
            if (gap != 0 && i != last) begin
                nvm_valid = 1'b0;
                nvm_bit   = ~nvm_bit;
                tick();
            end
        end
        nvm_valid = 1'b0;
    endtask

    // Called right after the parity-bit transfer of a good frame.
    task automatic expect_key(input string nm);
        logic [15:0] e;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_lat0: key_valid got %0b want 0", nm, key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_lat1: key_valid=%0b busy=%0b want 0/1", nm, key_valid, busy);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (key_valid !== 1'b1 || key_out !== e) begin
            errors++;
            $display("FAIL %s_key: valid=%0b key=%h want 1/%h", nm, key_valid, key_out, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({key_out, key_valid, nvm_req, busy, err, try_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL reset: key=%h kv=%0b req=%0b busy=%0b err=%0b try=%0d want all 0",
                     key_out, key_valid, nvm_req, busy, err, try_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_load();
        pulse_start();
        checks++;
        if (nvm_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_enter: req=%0b busy=%0b want 1/1", nvm_req, busy);
        end
        exp_q.push_back(16'hA5C3);
        send_bits(good_frame(16'hA5C3), 0, 16, 0);
        expect_key("good");
        checks++;
        if (try_cnt !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_try: try=%0d busy=%0b want 0/0", try_cnt, busy);
        end
    endtask

    task automatic test_bad_frame();
        pulse_start();
        checks++;
        if (key_valid !== 1'b0 || key_out !== 16'h0 || try_cnt !== 2'd0) begin
            errors++;
            $display("FAIL restart_clear: kv=%0b key=%h try=%0d want 0/0/0",
                     key_valid, key_out, try_cnt);
        end
        zero_viol = 0;
        send_bits(bad_frame(16'hA5C3), 0, 16, 0);
        tick();
        tick();
        checks++;
        if (try_cnt !== 2'd1 || nvm_req !== 1'b1 || zero_viol != 0 || key_out !== 16'h0) begin
            errors++;
            $display("FAIL bad_retry: try=%0d req=%0b zero_viol=%0d key=%h want 1/1/0/0",
                     try_cnt, nvm_req, zero_viol, key_out);
        end
        exp_q.push_back(16'hA5C3);
        send_bits(good_frame(16'hA5C3), 0, 16, 0);
        expect_key("bad_then_good");
    endtask

    task automatic test_lockout();
        test_reset();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            send_bits(bad_frame(16'h1234 + 16'(f)), 0, 16, 0);
            tick();
            tick();
        end
        checks++;
        if (err !== 1'b1 || key_out !== 16'h0 || nvm_req !== 1'b0 || try_cnt !== 2'd3) begin
            errors++;
            $display("FAIL lock: err=%0b key=%h req=%0b try=%0d want 1/0/0/3",
                     err, key_out, nvm_req, try_cnt);
        end
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (err !== 1'b1 || nvm_req !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_start: err=%0b req=%0b busy=%0b kv=%0b want 1/0/0/0",
                     err, nvm_req, busy, key_valid);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        pulse_start();
        send_bits(good_frame(16'hFFFF), 0, 4, 0);
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (try_cnt !== 2'd0 || nvm_req !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: try=%0d req=%0b want 0/1", try_cnt, nvm_req);
        end
        tick();
        checks++;
        if (try_cnt !== 2'd1 || nvm_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_hit: try=%0d req=%0b busy=%0b want 1/1/1",
                     try_cnt, nvm_req, busy);
        end
        exp_q.push_back(16'h3C96);
        send_bits(good_frame(16'h3C96), 0, 16, 0);
        expect_key("tmo_reload");
        checks++;
        if (try_cnt !== 2'd1) begin
            errors++;
            $display("FAIL tmo_try: try=%0d want 1", try_cnt);
        end
    endtask

    task automatic test_timeout_edge();
        test_reset();
        pulse_start();
        send_bits(good_frame(16'h5A17), 0, 2, 0);
        for (int i = 0; i < 254; i++) tick();
        exp_q.push_back(16'h5A17);
        send_bits(good_frame(16'h5A17), 3, 16, 0);
        expect_key("tmo_edge");
        checks++;
        if (try_cnt !== 2'd0) begin
            errors++;
            $display("FAIL tmo_edge_try: try=%0d want 0", try_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_bits(good_frame(16'hFFFF), 0, 7, 0);
        rst = 1'b1;
        #1;
        checks++;
        if ({key_out, key_valid, nvm_req, busy, err, try_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL mid_rst: key=%h kv=%0b req=%0b busy=%0b err=%0b try=%0d want all 0",
                     key_out, key_valid, nvm_req, busy, err, try_cnt);
        end
        tick();
        rst = 1'b0;
        // Stray valids while idle must not shift anything in.
        nvm_valid = 1'b1;
        nvm_bit   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        nvm_valid = 1'b0;
        checks++;
        if (nvm_req !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_idle: req=%0b busy=%0b kv=%0b want 0/0/0",
                     nvm_req, busy, key_valid);
        end
        pulse_start();
        exp_q.push_back(16'h0F0F);
        send_bits(good_frame(16'h0F0F), 0, 16, 0);
        expect_key("after_rst");
    endtask

    task automatic test_back_to_back();
        test_reset();
        pulse_start();
        exp_q.push_back(16'hC0DE);
        send_bits(good_frame(16'hC0DE), 0, 16, 1);
        expect_key("toggle");
        checks++;
        if (try_cnt !== 2'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL toggle_try: try=%0d err=%0b want 0/0", try_cnt, err);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_frame();
        test_lockout();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_load();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
